// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : trigger_capture
// Purpose  : Oscilloscope capture stage. Filtered samples are written into a
//            circular buffer. Level/edge trigger logic freezes the buffer with
//            a programmable number of pre-trigger samples. A registered
//            random-access read port fetches the frozen waveform.
// Ports    :
//   clk_i          rising-edge clock
//   rstn_i         synchronous reset, active-low
//   arm_i          one-cycle pulse, starts/restarts a capture
//   trig_mode_i    00 rising, 01 falling, 10 either, 11 force
//   trig_level_i   unsigned trigger threshold
//   pretrig_i      samples kept before the trigger (sampled on arm_i)
//   sample_i       filtered sample
//   sample_valid_i sample strobe
//   rd_addr_i      buffer read address
//   rd_data_o      buffer word at rd_addr_i, one clock latency
//   trig_addr_o    buffer index of the trigger sample
//   start_addr_o   buffer index of the oldest captured sample
//   busy_o         capture in progress
//   captured_o     capture complete, buffer frozen
// Revision : 1.0 - initial release
// ============================================================================
module trigger_capture #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 arm_i,
  input  logic [1:0]           trig_mode_i,
  input  logic [DATA_SIZE-1:0] trig_level_i,
  input  logic [ADDR_SIZE-1:0] pretrig_i,
  input  logic [DATA_SIZE-1:0] sample_i,
  input  logic                 sample_valid_i,
  input  logic [ADDR_SIZE-1:0] rd_addr_i,
  output logic [DATA_SIZE-1:0] rd_data_o,
  output logic [ADDR_SIZE-1:0] trig_addr_o,
  output logic [ADDR_SIZE-1:0] start_addr_o,
  output logic                 busy_o,
  output logic                 captured_o
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] C_LAST = (ADDR_SIZE+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0]   cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] pretrig_q, pretrig_d;
  logic [DATA_SIZE-1:0] prev_q, prev_d;
  logic                 prev_ok_q, prev_ok_d;
  logic [ADDR_SIZE-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_SIZE-1:0] start_addr_q, start_addr_d;
  logic [DATA_SIZE-1:0] rd_data_q;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic                 wr_en;
  logic                 hit_rise;
  logic                 hit_fall;
  logic                 trig_hit;
  logic [ADDR_SIZE:0]   pretrig_ext;
  logic [ADDR_SIZE:0]   post_len;

  // pretrig_i is ADDR_SIZE bits wide, so it can never exceed DEPTH-1 and
  // the clamp to min(pretrig, DEPTH-1) is inherent in the register width.
  assign pretrig_ext = {1'b0, pretrig_q};
  assign post_len    = C_LAST - pretrig_ext;

  assign hit_rise = prev_ok_q && (prev_q <  trig_level_i) && (sample_i >= trig_level_i);
  assign hit_fall = prev_ok_q && (prev_q >= trig_level_i) && (sample_i <  trig_level_i);

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_i)
      2'b00:   trig_hit = hit_rise;
      2'b01:   trig_hit = hit_fall;
      2'b10:   trig_hit = hit_rise | hit_fall;
      default: trig_hit = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    pretrig_d    = pretrig_q;
    prev_d       = prev_q;
    prev_ok_d    = prev_ok_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    wr_en        = 1'b0;

    if (arm_i) begin
      // Arm overrides everything, including a coincident sample.
      state_d   = S_PRE;
      cnt_d     = '0;
      wr_ptr_d  = '0;
      prev_ok_d = 1'b0;
      pretrig_d = pretrig_i;
    end else begin
      case (state_q)
        S_PRE: begin
          if (cnt_q == pretrig_ext) begin
            // Only reachable with zero pre-trigger: one idle cycle.
            state_d = S_WAIT;
          end else if (sample_valid_i) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + (ADDR_SIZE+1)'(1);
            if (cnt_q + (ADDR_SIZE+1)'(1) == pretrig_ext) begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (sample_valid_i) begin
            wr_en = 1'b1;
            if (trig_hit) begin
              trig_addr_d  = wr_ptr_q;
              start_addr_d = wr_ptr_q - pretrig_q;
              cnt_d        = post_len;
              state_d      = (post_len == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_valid_i) begin
            wr_en = 1'b1;
            cnt_d = cnt_q - (ADDR_SIZE+1)'(1);
            if (cnt_q == (ADDR_SIZE+1)'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    if (wr_en) begin
      wr_ptr_d  = wr_ptr_q + ADDR_SIZE'(1);
      prev_d    = sample_i;
      prev_ok_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pretrig_q    <= '0;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      pretrig_q    <= pretrig_d;
      prev_q       <= prev_d;
      prev_ok_q    <= prev_ok_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  // Buffer RAM: contents survive reset; writes are suppressed while in reset.
  always_ff @(posedge clk_i) begin
    if (rstn_i && wr_en) begin
      mem[wr_ptr_q] <= sample_i;
    end
  end

  // Registered read; a same-cycle write to rd_addr_i returns the old word.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o    = rd_data_q;
  assign trig_addr_o  = trig_addr_q;
  assign start_addr_o = start_addr_q;
  assign busy_o       = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign captured_o   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_capture
// Purpose  : Self-checking bench for trigger_capture (DEPTH=16). A sample-
//            count model predicts the buffer, trigger index and status
//            outputs; every cycle the DUT is compared against it, and
//            directed scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          arm = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] lvl = '0;
  logic [AW-1:0] pretrig = '0;
  logic [DW-1:0] sample = '0;
  logic          sv = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;
  logic          busy;
  logic          captured;

  int n_checks = 0;
  int n_pass   = 0;

  trigger_capture #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .arm_i          (arm),
    .trig_mode_i    (mode),
    .trig_level_i   (lvl),
    .pretrig_i      (pretrig),
    .sample_i       (sample),
    .sample_valid_i (sv),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .trig_addr_o    (trig_addr),
    .start_addr_o   (start_addr),
    .busy_o         (busy),
    .captured_o     (captured)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Samples are numbered from 0 after each arm; sample n lands at n mod 16.
  // The trigger may only fire on sample n >= p, and the capture ends once
  // trigger index + (DEPTH - p) samples have been stored.
  bit          m_init = 0;
  bit          m_active = 0;
  bit          m_done = 0;
  bit          m_skip = 0;
  bit          m_prev_ok = 0;
  int          m_n = 0;
  int          m_trig = -1;
  int          m_p = 0;
  logic [DW-1:0] m_prev = '0;
  logic [DW-1:0] m_mem [DEPTH];
  bit          m_ok [DEPTH];
  logic [AW-1:0] m_trig_addr = '0;
  logic [AW-1:0] m_start = '0;
  logic [DW-1:0] m_rd = '0;
  bit          m_rd_known = 0;

  function automatic bit fires(input logic [1:0] md, input logic [DW-1:0] level,
                               input bit pok, input logic [DW-1:0] pv,
                               input logic [DW-1:0] s);
    bit r, f;
    r = pok && (pv < level) && (s >= level);
    f = pok && (pv >= level) && (s < level);
    case (md)
      2'b00:   return r;
      2'b01:   return f;
      2'b10:   return r || f;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) m_ok[i] = 0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_active    = 0;
        m_done      = 0;
        m_trig_addr = '0;
        m_start     = '0;
        m_rd        = '0;
        m_rd_known  = 1;
        m_prev_ok   = 0;
        m_skip      = 0;
        m_init      = 1;
      end else begin
        m_rd       = m_mem[rd_addr];
        m_rd_known = m_ok[rd_addr];
        if (arm) begin
          m_active  = 1;
          m_done    = 0;
          m_n       = 0;
          m_trig    = -1;
          m_p       = int'(pretrig);
          m_skip    = (m_p == 0);
          m_prev_ok = 0;
        end else if (m_active) begin
          if (m_skip) begin
            m_skip = 0;
          end else if (sv) begin
            if (m_trig < 0 && m_n >= m_p && fires(mode, lvl, m_prev_ok, m_prev, sample)) begin
              m_trig      = m_n;
              m_trig_addr = AW'(m_n % DEPTH);
              m_start     = AW'((m_n - m_p) % DEPTH);
            end
            m_mem[m_n % DEPTH] = sample;
            m_ok[m_n % DEPTH]  = 1;
            m_prev    = sample;
            m_prev_ok = 1;
            m_n++;
            if (m_trig >= 0 && m_n == m_trig + DEPTH - m_p) begin
              m_active = 0;
              m_done   = 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("busy", int'(busy), int'(m_active));
        chk("captured", int'(captured), int'(m_done));
        chk("trig_addr", int'(trig_addr), int'(m_trig_addr));
        chk("start_addr", int'(start_addr), int'(m_start));
        if (m_rd_known) chk("rd_data", int'(rd_data), int'(m_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [DW-1:0] s, input bit a);
    arm    = a;
    sv     = v;
    sample = s;
    @(negedge clk);
    arm = 1'b0;
    sv  = 1'b0;
  endtask

  task automatic send(input int s);
    drive(1'b1, DW'(s), 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic do_arm(input int p, input logic [1:0] md, input int level);
    pretrig = AW'(p);
    mode    = md;
    lvl     = DW'(level);
    drive(1'b0, '0, 1'b1);
    pretrig = AW'(p + 5);  // must be ignored until the next arm
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic rd_lit(input int addr, input int exp, input string name);
    rd_addr = AW'(addr);
    @(negedge clk);
    chk(name, int'(rd_data), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_captured", int'(captured), 0);
    chk("rst_trig", int'(trig_addr), 0);
    chk("rst_start", int'(start_addr), 0);
    chk("rst_rd", int'(rd_data), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Rising edge, pretrig 4, level 100
    do_arm(4, 2'b00, 100);
    for (int i = 0; i <= 20; i++) send(10 * i);
    chk("rise_not_done", int'(captured), 0);
    send(210);
    chk("rise_captured", int'(captured), 1);
    chk("rise_trig", int'(trig_addr), 10);
    chk("rise_start", int'(start_addr), 6);
    chk("rise_model_trig", int'(m_trig_addr), 10);
    send(220);
    send(230);
    for (int k = 0; k < DEPTH; k++) rd_lit((6 + k) % DEPTH, 60 + 10 * k, "rise_rd");

    // Falling edge, pretrig 0, level 50
    do_arm(0, 2'b01, 50);
    send(80); send(60); send(40);
    chk("fall_trig", int'(trig_addr), 2);
    chk("fall_start", int'(start_addr), 2);
    for (int i = 0; i < 14; i++) send(100 + i);
    chk("fall_not_done", int'(captured), 0);
    send(114);
    chk("fall_captured", int'(captured), 1);
    rd_lit(2, 40, "fall_rd_trig");
    rd_lit(1, 114, "fall_rd_last");

    // Force, pretrig 15
    do_arm(15, 2'b11, 0);
    for (int i = 1; i <= 15; i++) send(i);
    chk("force_busy", int'(busy), 1);
    chk("force_not_done", int'(captured), 0);
    drive(1'b1, 16'd16, 1'b0);
    chk("force_captured", int'(captured), 1);
    chk("force_trig", int'(trig_addr), 15);
    chk("force_start", int'(start_addr), 0);
    for (int k = 0; k < DEPTH; k++) rd_lit(k, k + 1, "force_rd");

    // Wrap in wait: pretrig 3, level 1000
    do_arm(3, 2'b00, 1000);
    for (int i = 0; i <= 42; i++) send(10 * i);
    send(2000);
    chk("wrap_trig", int'(trig_addr), 11);
    chk("wrap_start", int'(start_addr), 8);
    for (int i = 0; i < 12; i++) send(1500);
    chk("wrap_captured", int'(captured), 1);
    rd_lit(8, 400, "wrap_rd8");
    rd_lit(9, 410, "wrap_rd9");
    rd_lit(10, 420, "wrap_rd10");
    rd_lit(11, 2000, "wrap_rd11");

    // Back-to-back, either edge, level 50; first sample must not edge-trigger
    do_arm(0, 2'b10, 50);
    for (int i = 0; i < 32; i++) drive(1'b1, (i < 5) ? 16'd10 : 16'd90, 1'b0);
    chk("b2b_captured", int'(captured), 1);
    chk("b2b_trig", int'(trig_addr), 5);
    chk("b2b_start", int'(start_addr), 5);
    chk("b2b_model_n", m_n, 21);
    rd_lit(5, 90, "b2b_rd5");

    // Abort mid-post with coincident sample, then reset mid-wait
    do_arm(4, 2'b00, 100);
    for (int i = 0; i <= 12; i++) send(10 * i);
    pretrig = 4'd4;
    drive(1'b1, 16'd999, 1'b1);
    chk("abort_busy", int'(busy), 1);
    chk("abort_captured", int'(captured), 0);
    chk("abort_trig_kept", int'(trig_addr), 10);
    send(7);
    rd_lit(0, 7, "abort_wrptr0");
    send(8); send(9); send(10);
    chk("abort_busy_wait", int'(busy), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_captured", int'(captured), 0);
    chk("rst2_trig", int'(trig_addr), 0);
    chk("rst2_start", int'(start_addr), 0);
    chk("rst2_rd", int'(rd_data), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
